spi_flash_reader: RTL and testbench

SPI_FLASH_READER -- requirements
Module: spi_flash_reader

---
 rtl/spi_flash_reader.sv | 144 ++++++++++++++
 tb/tb_spi_flash_reader.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_reader.sv
// SPI NOR flash reader: issues a 0x03 READ with a 24-bit address and returns
// the next four bytes as a little-endian 32-bit word (SPI mode 0).
module spi_flash_reader #(
  parameter int CLK_DIV = 2,
  parameter int CS_GAP  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [23:0] req_addr,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        spi_csb,
  output logic        spi_clk,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  localparam logic [7:0] CMD_READ = 8'h03;
  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  // The IDLE cycle before the next acceptance also keeps CSB high.
  localparam logic [7:0] GAP_LAST = (CS_GAP > 1) ? 8'(CS_GAP - 2) : 8'd0;

  function automatic logic [31:0] byte_swap(input logic [31:0] v);
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

  state_t      r_state, w_state;
  logic [7:0]  r_div, w_div;
  logic [5:0]  r_bit, w_bit;
  logic [31:0] r_shift, w_shift;
  logic [31:0] r_data, w_data;
  logic        r_ready, w_ready;
  logic        r_rsp_valid, w_rsp_valid;
  logic        r_csb, w_csb;
  logic        r_sclk, w_sclk;
  logic        r_mosi, w_mosi;

  assign req_ready = r_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_data;
  assign spi_csb   = r_csb;
  assign spi_clk   = r_sclk;
  assign spi_mosi  = r_mosi;

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_div       <= 8'd0;
      r_bit       <= 6'd0;
      r_shift     <= 32'd0;
      r_data      <= 32'd0;
      r_ready     <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_csb       <= 1'b1;
      r_sclk      <= 1'b0;
      r_mosi      <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_div       <= w_div;
      r_bit       <= w_bit;
      r_shift     <= w_shift;
      r_data      <= w_data;
      r_ready     <= w_ready;
      r_rsp_valid <= w_rsp_valid;
      r_csb       <= w_csb;
      r_sclk      <= w_sclk;
      r_mosi      <= w_mosi;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state     = r_state;
    w_div       = r_div;
    w_bit       = r_bit;
    w_shift     = r_shift;
    w_data      = r_data;
    w_rsp_valid = 1'b0;
    w_csb       = r_csb;
    w_sclk      = r_sclk;
    w_mosi      = r_mosi;
    case (r_state)
      S_IDLE: begin
        if (req_valid && r_ready) begin
          w_state = S_SHIFT;
          w_div   = 8'd0;
          w_bit   = 6'd0;
          w_shift = {CMD_READ, req_addr};
          w_csb   = 1'b0;
          w_sclk  = 1'b0;
          w_mosi  = CMD_READ[7];
        end else begin
          w_state = S_IDLE;
        end
      end
      S_SHIFT: begin
        if (r_div != DIV_LAST) begin
          w_div = r_div + 8'd1;
        end else if (!r_sclk) begin
          w_div  = 8'd0;
          w_sclk = 1'b1;
        end else begin
          // End of a high phase: advance MOSI and sample MISO (in-bits only).
          w_div   = 8'd0;
          w_sclk  = 1'b0;
          w_shift = {r_shift[30:0], (r_bit >= 6'd32) ? spi_miso : 1'b0};
          w_mosi  = (r_bit < 6'd31) ? r_shift[30] : 1'b0;
          if (r_bit == 6'd63) begin
            w_state     = S_GAP;
            w_csb       = 1'b1;
            w_rsp_valid = 1'b1;
            w_data      = byte_swap(w_shift);
          end else begin
            w_bit = r_bit + 6'd1;
          end
        end
      end
      S_GAP: begin
        if (r_div == GAP_LAST) begin
          w_state = S_IDLE;
        end else begin
          w_div = r_div + 8'd1;
        end
      end
      default: begin
        w_state = S_IDLE;
        w_csb   = 1'b1;
        w_sclk  = 1'b0;
        w_mosi  = 1'b0;
      end
    endcase
    w_ready = (w_state == S_IDLE);
  end

endmodule

// File: tb/tb_spi_flash_reader.sv
// Bench for spi_flash_reader: two instances (CLK_DIV=2 and CLK_DIV=1) talking
// to a behavioural flash, with table-driven and hand-written sequences.
module tb_spi_flash_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  req_ready;
  logic [23:0] req_addr [2];
  logic [1:0]  rsp_valid;
  logic [31:0] rsp_data [2];
  logic [1:0]  spi_csb;
  logic [1:0]  spi_clk;
  logic [1:0]  spi_mosi;

  logic [7:0]  mem [0:1023];
  int          n_vec = 0;
  int          n_fail = 0;

  typedef struct {
    int          sel;
    logic [23:0] addr;
    logic [31:0] exp;
    int          lat;
  } vec_t;
  vec_t tv [$];

  always #5 clk = ~clk;

  function automatic logic flash_bit(input logic [31:0] c, input int n);
    logic [7:0] b;
    int a;
    if (c[31:24] != 8'h03) return 1'b1;
    a = (int'(c[23:0]) + n / 8) % 1024;
    b = mem[a];
    return b[7 - (n % 8)];
  endfunction

  function automatic logic [31:0] ref_word(input int a);
    return {mem[a + 3], mem[a + 2], mem[a + 1], mem[a]};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_inst
    logic        miso_g = 1'b0;
    logic        p_mosi = 1'b0;
    logic [31:0] cap = 32'd0;
    logic [31:0] last_cap = 32'd0;
    int          k = 0;
    int          wviol = 0;
    int          pviol = 0;

    spi_flash_reader #(.CLK_DIV(g == 0 ? 2 : 1), .CS_GAP(4)) u_dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid[g]), .req_ready(req_ready[g]), .req_addr(req_addr[g]),
      .rsp_valid(rsp_valid[g]), .rsp_data(rsp_data[g]),
      .spi_csb(spi_csb[g]), .spi_clk(spi_clk[g]), .spi_mosi(spi_mosi[g]),
      .spi_miso(miso_g)
    );

    // Flash slave: capture command/address on SCLK rise, present data during high phase.
    always @(posedge spi_clk[g] or posedge spi_csb[g]) begin
      if (spi_csb[g]) begin
        if (!rst && k != 64) wviol++;
        last_cap = cap;
        k = 0;
        miso_g = 1'b0;
      end else begin
        if (k < 32) cap = {cap[30:0], spi_mosi[g]};
        else miso_g = flash_bit(cap, k - 32);
        k++;
      end
    end

    // Line rules: MOSI steady while SCLK high, SCLK low whenever CSB high.
    always @(negedge clk) begin
      if (spi_clk[g] && (spi_csb[g] || spi_mosi[g] !== p_mosi)) pviol++;
      p_mosi = spi_mosi[g];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic accept(input int sel, input logic [23:0] a, input bit hold);
    int n;
    @(negedge clk);
    req_valid[sel] = 1'b1;
    req_addr[sel]  = a;
    n = 0;
    while (!req_ready[sel] && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("accept_in_time", 32'(n < 5000), 32'd1);
    @(posedge clk);
    #1;
    if (!hold) req_valid[sel] = 1'b0;
  endtask

  task automatic wait_rsp(input int sel, output int lat, output logic [31:0] d, output bit ok);
    lat = 0;
    ok  = 1'b0;
    d   = 32'd0;
    while (!ok && lat < 2000) begin
      @(posedge clk);
      #1;
      lat++;
      if (rsp_valid[sel]) begin
        ok = 1'b1;
        d  = rsp_data[sel];
      end
    end
    chk("rsp_in_time", 32'(ok), 32'd1);
  endtask

  function automatic logic [31:0] get_cap(input int sel);
    return (sel == 0) ? g_inst[0].last_cap : g_inst[1].last_cap;
  endfunction

  initial begin
    int          lat, gap, seen;
    logic [31:0] d;
    bit          ok;

    for (int i = 0; i < 1024; i++) mem[i] = 8'(i * 37 + 11);
    mem[256] = 8'h11; mem[257] = 8'h22; mem[258] = 8'h33; mem[259] = 8'h44;
    mem[3]   = 8'hAA; mem[4]   = 8'hBB; mem[5]   = 8'hCC; mem[6]   = 8'hDD;
    req_addr[0] = 24'd0;
    req_addr[1] = 24'd0;

    tv.push_back('{sel: 0, addr: 24'h000100, exp: 32'h44332211, lat: 256});
    tv.push_back('{sel: 1, addr: 24'h000003, exp: 32'hDDCCBBAA, lat: 128});
    for (int i = 0; i < 8; i++) begin
      vec_t v;
      v.sel  = int'($urandom_range(0, 1));
      v.addr = 24'($urandom_range(0, 1020));
      v.exp  = ref_word(int'(v.addr));
      v.lat  = 128 * ((v.sel == 0) ? 2 : 1);
      tv.push_back(v);
    end

    // Reset values appear without any clock edge.
    rst = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_csb", 32'(spi_csb), 32'h3);
    chk("rst_sclk", 32'(spi_clk), 32'h0);
    chk("rst_mosi", 32'(spi_mosi), 32'h0);
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_data", rsp_data[0], 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1 chk("ready_before_edge", 32'(req_ready), 32'h0);
    @(posedge clk);
    #1 chk("ready_after_edge", 32'(req_ready), 32'h3);

    for (int i = 0; i < tv.size(); i++) begin
      accept(tv[i].sel, tv[i].addr, 1'b0);
      wait_rsp(tv[i].sel, lat, d, ok);
      if (ok) begin
        chk("rsp_data", d, tv[i].exp);
        chk("latency", 32'(lat), 32'(tv[i].lat));
        chk("mosi_stream", get_cap(tv[i].sel), {8'h03, tv[i].addr});
        chk("ready_low_at_rsp", 32'(req_ready[tv[i].sel]), 32'd0);
        @(posedge clk);
        #1 chk("rsp_one_cycle", 32'(rsp_valid[tv[i].sel]), 32'd0);
        repeat (3) @(posedge clk);
        #1 chk("rsp_data_hold", rsp_data[tv[i].sel], tv[i].exp);
      end
    end

    // Back-to-back: request held high across the gap.
    accept(0, 24'h000000, 1'b1);
    req_addr[0] = 24'h000004;
    wait_rsp(0, lat, d, ok);
    chk("b2b_first", d, ref_word(0));
    gap = 0;
    @(negedge clk);
    while (spi_csb[0] && gap < 100) begin
      gap++;
      @(negedge clk);
    end
    req_valid[0] = 1'b0;
    chk("b2b_csb_gap", 32'(gap), 32'd4);
    wait_rsp(0, lat, d, ok);
    chk("b2b_second", d, ref_word(4));

    // Reset during the address phase aborts the read.
    accept(0, 24'h000100, 1'b0);
    repeat (48) @(posedge clk);
    @(negedge clk);
    chk("mid_csb_low", 32'(spi_csb[0]), 32'd0);
    rst = 1'b1;
    #1;
    chk("abort_csb", 32'(spi_csb[0]), 32'd1);
    chk("abort_sclk", 32'(spi_clk[0]), 32'd0);
    chk("abort_ready", 32'(req_ready[0]), 32'd0);
    chk("abort_data", rsp_data[0], 32'd0);
    seen = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (300) begin
      @(negedge clk);
      if (rsp_valid[0]) seen++;
    end
    chk("abort_no_rsp", 32'(seen), 32'd0);
    accept(0, 24'h000100, 1'b0);
    wait_rsp(0, lat, d, ok);
    chk("after_abort_data", d, 32'h44332211);
    chk("after_abort_latency", 32'(lat), 32'd256);

    repeat (10) @(negedge clk);
    chk("line_rules_div2", 32'(g_inst[0].pviol), 32'd0);
    chk("line_rules_div1", 32'(g_inst[1].pviol), 32'd0);
    chk("edges_per_window_div2", 32'(g_inst[0].wviol), 32'd0);
    chk("edges_per_window_div1", 32'(g_inst[1].wviol), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
